mult_booth_unit: RTL and testbench
==================================

// Module: mult_booth_unit
// PURPOSE
// Iterative radix-2 Booth multiplier for the execute stage, alongside the 32-bit CLA adder.
// - Latches two signed 32-bit operands on a start pulse.
// - Runs one add/subtract-and-shift step per clock and reports the low 32 product bits plus a
//   signed-overflow flag.
// - Drives its own adder internally and presents a one-cycle ready pulse to the stall/writeback logic.
// PARAMETERS
// WIDTH    32  operand/result width; only 32 is supported
// CNT_W    6   step-counter width; must hold values 0..WIDTH
// PORTS
// clock           in   1   rising-edge clock for all state
// reset_n         in   1   synchronous, active-low reset
// ctrl_MULT       in   1   start pulse; sampled on every rising edge
// data_operandA   in   32  multiplicand, signed; sampled only on the edge where ctrl_MULT=1
// data_operandB   in   32  multiplier, signed; sampled only on the edge where ctrl_MULT=1
// data_result     out  32  product[31:0]; held stable from the ready pulse until the next start
// data_exception  out  1   1 if the signed 64-bit product does not fit in 32 bits; valid with data_result
// data_resultRDY  out  1   one-cycle pulse when data_result/data_exception become valid
// busy            out  1   1 while state==RUN
// BEHAVIOUR
// - Reset (reset_n=0 at an edge):
//   - state=IDLE; count=0; product register=0.
//   - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
//   - Reset wins over ctrl_MULT and aborts any operation in progress; no ready pulse follows.
// - States: IDLE, RUN, DONE.
//   - IDLE --ctrl_MULT--> RUN
//   - RUN --(count==WIDTH-1)--> DONE
//   - DONE --> IDLE, or --> RUN if ctrl_MULT=1
// - Start edge (ctrl_MULT=1 in any state):
//   - M <= sign-extended 33-bit data_operandA.
//   - P <= {33'b0, data_operandB, 1'b0}, i.e. 66 bits: acc[32:0] | mplr[31:0] | q_-1.
//   - count <= 0; state <= RUN.
//   - ctrl_MULT during RUN aborts the current operation and restarts with the new operands.
// - RUN step, one per edge, on P[1:0]:
//   - 01: acc += M
//   - 10: acc -= M
//   - 00/11: no change
//   - Then arithmetic-shift the whole of P right by 1; count <= count+1.
//   - acc is 33 bits, so M = -2^31 cannot overflow the accumulator.
//   - The 32-bit adder may implement acc[31:0]; bit 32 is computed as a sign-extended sum.
// - Completion, on the edge executing step WIDTH-1:
//   - state <= DONE.
//   - data_result <= final P[32:1] (product[31:0]).
//   - data_exception <= (product[63:32] != {32{product[31]}}).
// - Latency: with the start edge as edge 0, data_resultRDY=1 in the cycle after edge 32. Exactly
//   32 RUN cycles, then 1 DONE cycle.
// - data_resultRDY=1 only in DONE; never asserted twice for one start.
// - Start in DONE: the pulse for the finished op still shows that cycle; the new op proceeds normally.
// - Outputs are registered; no combinational path from inputs to outputs.
// - Operand inputs are ignored outside start edges; they may change freely during RUN.
// TESTING
// 1. A=3, B=4, pulse ctrl_MULT -> RDY exactly 33 cycles later, result=0x0000000C, exc=0, busy=1
//    for 32 cycles.
// 2. A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6, exc=0. Also A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exc=0.
// 3. A=B=0x80000000 -> result=0x00000000, exc=1. Also A=B=0x00010000 -> result=0, exc=1.
//    Also A=0x80000000, B=-1 -> result=0x80000000, exc=1.
// 4. Start A=5,B=5; at cycle 10 pulse ctrl_MULT with A=2,B=-3 -> single RDY 33 cycles after the
//    second start, result=0xFFFFFFFA.
// 5. Start A=9,B=9; drive reset_n=0 at cycle 15 for 1 cycle -> all outputs 0, no RDY pulse ever;
//    a fresh start then completes normally (81).
// 6. Back-to-back: assert ctrl_MULT in the DONE cycle -> RDY for the first op that cycle, second
//    RDY 33 cycles later; data_result holds the first product until then.

Source files
------------

// File: rtl/mult_booth_unit_if.sv
// Operand/result bundle for the iterative Booth multiplier.
// The master issues operands and a start pulse. The slave returns the product, overflow flag and status.
interface mult_booth_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_unit.sv
// Iterative radix-2 Booth multiplier. It performs one add/subtract-and-shift step per clock.
// It reports product[31:0], a signed-overflow flag, and a one-cycle ready pulse.
module mult_booth_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  mult_booth_unit_if.slave    bus
);

  localparam int PW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH:0]   m_q;
  logic [PW-1:0]           p_q;
  logic [PW-1:0]           p_step;
  logic [CNT_W-1:0]        count_q;
  logic [WIDTH-1:0]        result_q;
  logic                    exc_q;
  logic signed [WIDTH:0]   acc;
  logic signed [WIDTH:0]   acc_sum;
  logic                    last_step;

  // The product overflows when its upper half is not the sign extension of the lower half.
  function automatic logic prod_ovf(input logic signed [2*WIDTH-1:0] prod);
    return prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  endfunction

  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  // The 33-bit accumulator absorbs M = -2^31 without wrapping.
  always_comb begin
    acc     = p_q[PW-1:WIDTH+1];
    acc_sum = acc;
    case (p_q[1:0])
      2'b01:   acc_sum = acc + m_q;
      2'b10:   acc_sum = acc - m_q;
      default: acc_sum = acc;
    endcase
    p_step = {acc_sum[WIDTH], acc_sum, p_q[WIDTH:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ctrl_MULT) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (last_step) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // A start edge takes priority over a step and restarts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      m_q      <= '0;
      p_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      m_q     <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
      p_q     <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
      count_q <= '0;
    end else if (state_q == RUN) begin
      p_q     <= p_step;
      count_q <= count_q + 1'b1;
      if (last_step) begin
        result_q <= p_step[WIDTH:1];
        exc_q    <= prod_ovf(p_step[2*WIDTH:1]);
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_booth_unit.sv
// Self-checking bench for mult_booth_unit. It checks results against a 64-bit signed-multiply reference model.
module tb_mult_booth_unit;

  logic clock;
  logic reset_n;
  int   tests;
  int   fails;

  mult_booth_unit_if #(.WIDTH(32)) bus ();

  mult_booth_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    longint lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = longint'($signed(p[31:0]));
    r  = p[31:0];
    e  = (p != lo);
  endfunction

  // Pulse start across one rising edge. Return at the falling edge after that start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
  endtask

  // Start an operation and wait for ready while scrambling the operand inputs.
  // Latency is the index of the edge after which ready is seen, or -1 if ready never arrives.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] res, output logic exc, output int busy_cnt);
    lat      = -1;
    res      = '0;
    exc      = 1'b0;
    busy_cnt = 0;
    start_op(a, b);
    if (bus.busy) busy_cnt++;
    for (int n = 1; n <= 40; n++) begin
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.data_resultRDY) begin
        lat = n;
        res = bus.data_result;
        exc = bus.data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    repeat (3) @(negedge clock);
    tests++;
    if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, need all 0",
               bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
    end
    bus.ctrl_MULT = 1'b0;
    reset_n       = 1'b1;
    @(negedge clock);
    tests++;
    if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b rdy=%b, need 0 0", bus.busy, bus.data_resultRDY);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [7] = '{32'd3, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000,
                            32'h00010000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] vb [7] = '{32'd4, 32'd6, 32'd1, 32'h80000000,
                            32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] er, res;
    logic        ee, exc;
    int          lat, bc;
    for (int i = 0; i < 7; i++) begin
      model(va[i], vb[i], er, ee);
      run_op(va[i], vb[i], lat, res, exc, bc);
      tests++;
      if (lat !== 32) begin
        fails++;
        $display("FAIL dir%0d_latency: got %0d, need 32", i, lat);
      end
      tests++;
      if (res !== er || exc !== ee) begin
        fails++;
        $display("FAIL dir%0d_result: got %h/%b, need %h/%b", i, res, exc, er, ee);
      end
      tests++;
      if (bc !== 32) begin
        fails++;
        $display("FAIL dir%0d_busy_cycles: got %0d, need 32", i, bc);
      end
      @(negedge clock);
      tests++;
      if (bus.data_resultRDY !== 1'b0 || bus.data_result !== er) begin
        fails++;
        $display("FAIL dir%0d_pulse_hold: got rdy=%b res=%h, need 0/%h",
                 i, bus.data_resultRDY, bus.data_result, er);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, er, res;
    logic        ee, exc;
    int          lat, bc;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >>> 20;
      model(a, b, er, ee);
      run_op(a, b, lat, res, exc, bc);
      tests++;
      if (lat !== 32 || res !== er || exc !== ee) begin
        fails++;
        $display("FAIL rand%0d a=%h b=%h: got lat=%0d %h/%b, need 32 %h/%b",
                 i, a, b, lat, res, exc, er, ee);
      end
    end
  endtask

  task automatic test_restart();
    int pulses, first;
    logic [31:0] er, res;
    logic        ee;
    model(32'd2, 32'hFFFFFFFD, er, ee);
    start_op(32'd5, 32'd5);
    repeat (8) @(negedge clock);
    start_op(32'd2, 32'hFFFFFFFD);
    pulses = 0;
    first  = -1;
    res    = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first = n;
          res   = bus.data_result;
        end
      end
    end
    tests++;
    if (pulses !== 1 || first !== 32) begin
      fails++;
      $display("FAIL restart_pulse: got %0d pulses first at %0d, need 1 at 32", pulses, first);
    end
    tests++;
    if (res !== er || res !== 32'hFFFFFFFA) begin
      fails++;
      $display("FAIL restart_result: got %h, need %h", res, er);
    end
  endtask

  task automatic test_reset_abort();
    int          pulses, lat, bc;
    logic [31:0] res;
    logic        exc;
    start_op(32'd9, 32'd9);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tests++;
    if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
      fails++;
      $display("FAIL abort_outputs: got res=%h exc=%b rdy=%b busy=%b, need all 0",
               bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_rdy: got %0d active cycles, need 0", pulses);
    end
    run_op(32'd9, 32'd9, lat, res, exc, bc);
    tests++;
    if (lat !== 32 || res !== 32'd81 || exc !== 1'b0) begin
      fails++;
      $display("FAIL abort_fresh: got lat=%0d %h/%b, need 32 00000051/0", lat, res, exc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2, res;
    logic        x1, x2, exc;
    int          lat, bc, lat2, held_bad;
    a1 = $urandom; b1 = $urandom >> 8;
    a2 = $urandom; b2 = 32'hFFFFF000 | ($urandom & 32'hFFF);
    model(a1, b1, e1, x1);
    model(a2, b2, e2, x2);
    run_op(a1, b1, lat, res, exc, bc);
    tests++;
    if (lat !== 32 || res !== e1 || exc !== x1) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d %h/%b, need 32 %h/%b", lat, res, exc, e1, x1);
    end
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a2;
    bus.data_operandB = b2;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.data_resultRDY !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart_state: got busy=%b rdy=%b, need 1 0", bus.busy, bus.data_resultRDY);
    end
    lat2     = -1;
    held_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        lat2 = n;
        res  = bus.data_result;
        exc  = bus.data_exception;
        break;
      end
      if (bus.data_result !== e1) held_bad++;
    end
    tests++;
    if (held_bad !== 0) begin
      fails++;
      $display("FAIL b2b_hold: got %0d cycles with result != %h, need 0", held_bad, e1);
    end
    tests++;
    if (lat2 !== 32 || res !== e2 || exc !== x2) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d %h/%b, need 32 %h/%b", lat2, res, exc, e2, x2);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
